noc_traffic_gen: RTL and testbench
==================================

Name: noc_traffic_gen

Overview:
- Synthesizable per-node traffic generator and receive monitor for the mesh NoC; one instance sits on each PE port in place of a processing element.
- Drives the PE write interface with configurable traffic patterns: fixed destination, all-node sweep, LFSR random, and QoS cycling.
- Counts transmitted, received and stalled cycles, so the mesh can be stressed on silicon/FPGA as well as in simulation.

Parameters:
- MESH_X, 4, mesh columns (1..16).
- MESH_Y, 4, mesh rows (1..16).
- NODE_W, 8, node-id width.
- DATA_W, 256, PE data width (>=64).
- ADDR_W, 64, PE address width (>=32).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- self_id  in  NODE_W  this node's id, static.
- start  in  1  pulse; begin a run with cfg_* latched this cycle.
- stop  in  1  pulse; end the run after the current transfer.
- cfg_mode  in  2  0 FIXED, 1 SWEEP, 2 RANDOM, 3 QOS_CYCLE.
- cfg_dst  in  NODE_W  destination for FIXED/QOS_CYCLE.
- cfg_count  in  16  packets per run; 0 = run until stop.
- cfg_gap  in  8  idle cycles between packets.
- cfg_qos  in  qos_level_t  QoS for modes 0-2.
- cfg_seed  in  16  LFSR seed; 0 replaced by 16'h0001.
- pe_addr  out  ADDR_W  destination address.
- pe_wdata  out  DATA_W  payload.
- pe_write  out  1  request valid.
- pe_read  out  1  constant 0.
- pe_size  out  3  constant 3'b011.
- pe_qos  out  qos_level_t  packet QoS.
- pe_ready  in  1  accept.
- pe_valid  in  1  received-data strobe.
- pe_rdata  in  DATA_W  received payload.
- busy  out  1  run active.
- done  out  1  one-cycle pulse at run end.
- cfg_err  out  1  one-cycle pulse on rejected start.
- tx_count  out  32  accepted packets (cumulative).
- rx_count  out  32  pe_valid cycles (cumulative).
- stall_cycles  out  32  cycles with pe_write=1 and pe_ready=0.

Behaviour:
- Reset: all outputs 0 except pe_size=3'b011; pe_qos=QOS_NORMAL; FSM to IDLE; LFSR=1; counters cleared.
- FSM states and transitions:
  - IDLE->REQ on start.
  - REQ->GAP on accept when cfg_gap>0.
  - REQ->REQ on accept when cfg_gap=0 (next payload presented the next cycle; pe_write stays 1).
  - GAP->REQ after cfg_gap cycles.
  - Any state->DONE when the final packet is accepted or a stop is pending. DONE lasts 1 cycle, then ->IDLE.
- Handshake:
  - Transfer occurs at a rising edge with pe_write&&pe_ready.
  - pe_addr, pe_wdata and pe_qos are stable while pe_write=1 and not accepted.
  - pe_write is never withdrawn before acceptance.
- Address mapping: pe_addr[31:28]=dst%MESH_X, pe_addr[27:24]=dst/MESH_X; all other bits 0.
- Payload:
  - wdata[63:56]=self_id[7:0].
  - wdata[31:0]=seq, which starts at 0 each run and increments per accepted packet.
  - All other bits 0.
- Destination per mode:
  - FIXED/QOS_CYCLE: cfg_dst.
  - SWEEP: ascending 0..NUM_NODES-1 skipping self_id, wrapping to 0 (or 1 if self_id=0).
  - RANDOM: lfsr%NUM_NODES; if this equals self_id, use (that+1)%NUM_NODES. The LFSR polynomial is x^16+x^14+x^13+x^11+1 and advances once per accepted packet.
- QoS: QOS_CYCLE emits LOW,NORMAL,HIGH,URGENT repeating, starting at LOW; the other modes use cfg_qos.
- Start rejection: start in modes 0/3 with cfg_dst==self_id or cfg_dst>=NUM_NODES is rejected with a cfg_err pulse, busy stays 0 and no packets are sent.
- busy is 1 from the cycle after an accepted start through DONE inclusive. done pulses in the DONE cycle.
- start while busy: ignored.
- stop in IDLE: ignored.
- start and stop in the same cycle from IDLE: stop wins, nothing starts.
- stop during REQ: the current packet completes, then DONE.
- stop during GAP: DONE next cycle.
- Counters saturate at all-ones and are never cleared except by rst.
- rst mid-run: immediate return to IDLE; pe_write=0 asynchronously.

Optional Feature:
- NOC_TG_LATENCY_EN defined:
  - A free-running 24-bit cycle counter is written into wdata[55:32] of each packet.
  - On each pe_valid the block computes lat = (now - pe_rdata[55:32]) mod 2^24.
  - Extra ports: lat_max out 24 (maximum lat) and lat_sum out 32 (saturating sum); both reset to 0.
- Undefined: wdata[55:32]=0, and the lat ports and cycle counter are absent.

Test Plan:
- FIXED, self=0, dst=1, count=3, gap=0, pe_ready=1:
  - 3 consecutive pe_write cycles with pe_addr[31:24]=8'h10 and seq 0,1,2.
  - done 1 cycle later; tx_count=3.
- SWEEP, self=5, count=15:
  - Destinations 0-4 then 6-15, never 5.
  - Final tx_count=15.
- Backpressure: pe_ready low 7 cycles during the first packet:
  - Payload held stable and stall_cycles=7.
  - The packet is accepted once, on the first ready edge.
- QOS_CYCLE, count=5: pe_qos sequence LOW,NORMAL,HIGH,URGENT,LOW.
- FIXED with dst=self_id:
  - cfg_err pulses 1 cycle; busy=0 and no writes.
  - Then count=0, gap=2, stop after 4 accepts: the in-flight packet completes, tx_count=5 and done pulses.
- rst asserted with pe_write=1 mid-run: pe_write=0 and busy=0 immediately; a subsequent start begins at seq 0.

Source files
------------

// File: rtl/noc_traffic_gen.sv
// noc_traffic_gen: per-node traffic generator and receive monitor for the mesh NoC.
// It sits on a PE port in place of a processing element. It drives the PE write
// interface with fixed, sweep, LFSR-random or QoS-cycling traffic, and it counts
// transmitted, received and stalled cycles.
// Optional build macro NOC_TG_LATENCY_EN: stamps a 24-bit cycle count into
// wdata[55:32] and tracks max/sum receive latency on the extra lat_* ports.

package noc_tg_pkg;
    typedef enum logic [1:0] {
        QOS_LOW    = 2'd0,
        QOS_NORMAL = 2'd1,
        QOS_HIGH   = 2'd2,
        QOS_URGENT = 2'd3
    } qos_level_t;

    typedef enum logic [1:0] {
        MODE_FIXED     = 2'd0,
        MODE_SWEEP     = 2'd1,
        MODE_RANDOM    = 2'd2,
        MODE_QOS_CYCLE = 2'd3
    } tg_mode_t;
endpackage

module noc_traffic_gen
    import noc_tg_pkg::*;
#(
    parameter int MESH_X = 4,
    parameter int MESH_Y = 4,
    parameter int NODE_W = 8,
    parameter int DATA_W = 256,
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NODE_W-1:0] self_id,
    input  logic              start,
    input  logic              stop,
    input  logic [1:0]        cfg_mode,
    input  logic [NODE_W-1:0] cfg_dst,
    input  logic [15:0]       cfg_count,
    input  logic [7:0]        cfg_gap,
    input  qos_level_t        cfg_qos,
    input  logic [15:0]       cfg_seed,
    output logic [ADDR_W-1:0] pe_addr,
    output logic [DATA_W-1:0] pe_wdata,
    output logic              pe_write,
    output logic              pe_read,
    output logic [2:0]        pe_size,
    output qos_level_t        pe_qos,
    input  logic              pe_ready,
    input  logic              pe_valid,
    input  logic [DATA_W-1:0] pe_rdata,
    output logic              busy,
    output logic              done,
    output logic              cfg_err,
    output logic [31:0]       tx_count,
    output logic [31:0]       rx_count,
    output logic [31:0]       stall_cycles
`ifdef NOC_TG_LATENCY_EN
    ,
    output logic [23:0]       lat_max,
    output logic [31:0]       lat_sum
`endif
);

    localparam int unsigned NUM_NODES = MESH_X * MESH_Y;

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_GAP, ST_DONE} state_t;

    state_t            state_q, state_d;
    tg_mode_t          mode_q;
    logic [NODE_W-1:0] dst_q;        // FIXED/QOS target, or current SWEEP position
    logic [15:0]       count_q;
    logic [7:0]        gap_cfg_q;
    logic [7:0]        gap_cnt_q;
    qos_level_t        qos_q;
    logic [15:0]       lfsr_q;
    logic [31:0]       seq_q;
    logic [31:0]       tx_q, rx_q, stall_q;
    logic              stop_pend_q;
    logic              cfg_err_q;

    logic              cfg_bad, start_ok, accept, last_pkt, stop_now;
    logic [NODE_W-1:0] cur_dst;
    logic              unused_rdata;

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        // x^16 + x^14 + x^13 + x^11 + 1, Fibonacci form
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    function automatic logic [NODE_W-1:0] sweep_first(input logic [NODE_W-1:0] self);
        return (self == '0) ? NODE_W'(1) : '0;
    endfunction

    function automatic logic [NODE_W-1:0] sweep_next(input logic [NODE_W-1:0] cur,
                                                     input logic [NODE_W-1:0] self);
        int unsigned n;
        n = 32'(cur) + 32'd1;
        if (n >= NUM_NODES) n = 0;
        if (n == 32'(self)) n = n + 32'd1;
        if (n >= NUM_NODES) n = 0;
        return NODE_W'(n);
    endfunction

    function automatic logic [NODE_W-1:0] rand_dst(input logic [15:0] l,
                                                   input logic [NODE_W-1:0] self);
        int unsigned n;
        n = 32'(l) % NUM_NODES;
        if (n == 32'(self)) n = (n + 32'd1) % NUM_NODES;
        return NODE_W'(n);
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    // Decode start validity, handshake and run-termination conditions
    always_comb begin
        cfg_bad  = ((cfg_mode == MODE_FIXED) || (cfg_mode == MODE_QOS_CYCLE)) &&
                   ((cfg_dst == self_id) || (32'(cfg_dst) >= NUM_NODES));
        start_ok = (state_q == ST_IDLE) && start && !stop && !cfg_bad;
        accept   = (state_q == ST_REQ) && pe_ready;
        last_pkt = (count_q != 16'd0) && (seq_q == {16'd0, count_q - 16'd1});
        stop_now = stop_pend_q || stop;
        cur_dst  = (mode_q == MODE_RANDOM) ? rand_dst(lfsr_q, self_id) : dst_q;
    end

    // State register; pe_write decodes from it, so rst drops pe_write asynchronously
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start_ok) state_d = ST_REQ;
            ST_REQ: begin
                if (accept) begin
                    if (last_pkt || stop_now)  state_d = ST_DONE;
                    else if (gap_cfg_q != '0)  state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (stop_now)                state_d = ST_DONE;
                else if (gap_cnt_q <= 8'd1)  state_d = ST_REQ;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef NOC_TG_LATENCY_EN
    logic [23:0] cyc_q, ts_q, lat_max_q, lat;
    logic [31:0] lat_sum_q;
    logic [32:0] lat_sum_wide;

    // Receive latency from the timestamp echoed in the payload
    always_comb begin
        lat          = cyc_q - pe_rdata[55:32];
        lat_sum_wide = {1'b0, lat_sum_q} + 33'(lat);
    end

    // Free-running cycle counter, per-packet timestamp and latency statistics
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_q     <= '0;
            ts_q      <= '0;
            lat_max_q <= '0;
            lat_sum_q <= '0;
        end else begin
            cyc_q <= cyc_q + 24'd1;
            // stamp each packet with the cycle in which it is first presented
            if (state_d == ST_REQ && (state_q != ST_REQ || accept)) ts_q <= cyc_q + 24'd1;
            if (pe_valid) begin
                if (lat > lat_max_q) lat_max_q <= lat;
                lat_sum_q <= lat_sum_wide[32] ? '1 : lat_sum_wide[31:0];
            end
        end
    end

    assign unused_rdata = ^{pe_rdata[DATA_W-1:56], pe_rdata[31:0]};
`else
    assign unused_rdata = ^pe_rdata;
`endif

    // Run configuration, sequence/LFSR/sweep/QoS progression, pending stop and counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q      <= MODE_FIXED;
            dst_q       <= '0;
            count_q     <= '0;
            gap_cfg_q   <= '0;
            gap_cnt_q   <= '0;
            qos_q       <= QOS_NORMAL;
            lfsr_q      <= 16'h0001;
            seq_q       <= '0;
            stop_pend_q <= 1'b0;
            cfg_err_q   <= 1'b0;
            tx_q        <= '0;
            rx_q        <= '0;
            stall_q     <= '0;
        end else begin
            if (start_ok) begin
                mode_q    <= tg_mode_t'(cfg_mode);
                dst_q     <= (cfg_mode == MODE_SWEEP) ? sweep_first(self_id) : cfg_dst;
                count_q   <= cfg_count;
                gap_cfg_q <= cfg_gap;
                gap_cnt_q <= cfg_gap;
                qos_q     <= (cfg_mode == MODE_QOS_CYCLE) ? QOS_LOW : cfg_qos;
                lfsr_q    <= (cfg_seed == 16'd0) ? 16'h0001 : cfg_seed;
                seq_q     <= '0;
            end else if (accept) begin
                seq_q     <= seq_q + 32'd1;
                lfsr_q    <= lfsr_next(lfsr_q);
                gap_cnt_q <= gap_cfg_q;
                if (mode_q == MODE_SWEEP)     dst_q <= sweep_next(dst_q, self_id);
                if (mode_q == MODE_QOS_CYCLE) qos_q <= qos_level_t'(2'(qos_q + 2'd1));
            end else if (state_q == ST_GAP) begin
                gap_cnt_q <= gap_cnt_q - 8'd1;
            end

            // a stop only matters while a run is active
            if (state_q == ST_REQ || state_q == ST_GAP) stop_pend_q <= stop_pend_q | stop;
            else                                        stop_pend_q <= 1'b0;

            cfg_err_q <= (state_q == ST_IDLE) && start && !stop && cfg_bad;

            if (accept)                           tx_q    <= sat_inc(tx_q);
            if (pe_valid)                         rx_q    <= sat_inc(rx_q);
            if (state_q == ST_REQ && !pe_ready)   stall_q <= sat_inc(stall_q);
        end
    end

    // Output decode; address/payload are driven only while a request is up
    always_comb begin
        pe_write     = 1'b0;
        pe_read      = 1'b0;
        pe_size      = 3'b011;
        pe_qos       = qos_q;
        pe_addr      = '0;
        pe_wdata     = '0;
        busy         = (state_q != ST_IDLE);
        done         = (state_q == ST_DONE);
        cfg_err      = cfg_err_q;
        tx_count     = tx_q;
        rx_count     = rx_q;
        stall_cycles = stall_q;
`ifdef NOC_TG_LATENCY_EN
        lat_max      = lat_max_q;
        lat_sum      = lat_sum_q;
`endif
        if (state_q == ST_REQ) begin
            pe_write        = 1'b1;
            pe_addr[31:28]  = 4'(32'(cur_dst) % MESH_X);
            pe_addr[27:24]  = 4'(32'(cur_dst) / MESH_X);
            pe_wdata[63:56] = self_id[7:0];
            pe_wdata[31:0]  = seq_q;
`ifdef NOC_TG_LATENCY_EN
            pe_wdata[55:32] = ts_q;
`endif
        end
    end

endmodule

// File: tb/tb_noc_traffic_gen.sv
// tb_noc_traffic_gen: directed bench for noc_traffic_gen on a 4x4 mesh.
// A vector table covers whole runs in each mode; hand-written sequences cover
// backpressure, start rejection, stop handling and mid-run reset.

module tb_noc_traffic_gen;
    import noc_tg_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   self_id;
    logic         start, stop;
    logic [1:0]   cfg_mode;
    logic [7:0]   cfg_dst;
    logic [15:0]  cfg_count;
    logic [7:0]   cfg_gap;
    qos_level_t   cfg_qos;
    logic [15:0]  cfg_seed;
    logic [63:0]  pe_addr;
    logic [255:0] pe_wdata;
    logic         pe_write, pe_read;
    logic [2:0]   pe_size;
    qos_level_t   pe_qos;
    logic         pe_ready, pe_valid;
    logic [255:0] pe_rdata;
    logic         busy, done, cfg_err;
    logic [31:0]  tx_count, rx_count, stall_cycles;
`ifdef NOC_TG_LATENCY_EN
    logic [23:0]  lat_max;
    logic [31:0]  lat_sum;
`endif

    int n_pass  = 0;
    int n_total = 0;

    noc_traffic_gen dut (
        .clk(clk), .rst(rst), .self_id(self_id), .start(start), .stop(stop),
        .cfg_mode(cfg_mode), .cfg_dst(cfg_dst), .cfg_count(cfg_count),
        .cfg_gap(cfg_gap), .cfg_qos(cfg_qos), .cfg_seed(cfg_seed),
        .pe_addr(pe_addr), .pe_wdata(pe_wdata), .pe_write(pe_write),
        .pe_read(pe_read), .pe_size(pe_size), .pe_qos(pe_qos),
        .pe_ready(pe_ready), .pe_valid(pe_valid), .pe_rdata(pe_rdata),
        .busy(busy), .done(done), .cfg_err(cfg_err),
        .tx_count(tx_count), .rx_count(rx_count), .stall_cycles(stall_cycles)
`ifdef NOC_TG_LATENCY_EN
        , .lat_max(lat_max), .lat_sum(lat_sum)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]       self_id;
        logic [1:0]       mode;
        logic [7:0]       dst;
        logic [15:0]      count;
        logic [7:0]       gap;
        logic [1:0]       qos;
        logic [15:0]      seed;
        int               npkt;
        logic [19:0][7:0] exp_dst;
        logic [19:0][1:0] exp_qos;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; stop = 1'b0; pe_ready = 1'b0; pe_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic set_cfg(input logic [7:0] s, input logic [1:0] m, input logic [7:0] d,
                           input logic [15:0] c, input logic [7:0] g);
        self_id = s; cfg_mode = m; cfg_dst = d; cfg_count = c; cfg_gap = g;
        cfg_qos = QOS_NORMAL; cfg_seed = 16'd1;
    endtask

    function automatic logic [255:0] exp_addr(input int d);
        logic [255:0] a;
        a = '0;
        a[31:28] = 4'(d % 4);
        a[27:24] = 4'(d / 4);
        return a;
    endfunction

    function automatic logic [255:0] exp_wdata(input logic [7:0] s, input int seq);
        logic [255:0] w;
        w = '0;
        w[63:56] = s;
        w[31:0]  = 32'(seq);
        return w;
    endfunction

    task automatic init_vecs();
        int k;
        for (int i = 0; i < 6; i++) begin
            vecs[i].exp_dst = '0; vecs[i].exp_qos = '0; vecs[i].seed = 16'd1; vecs[i].dst = 8'd0;
        end
        // FIXED self 0 -> 1, three back-to-back packets
        vecs[0].self_id = 8'd0; vecs[0].mode = 2'd0; vecs[0].dst = 8'd1; vecs[0].count = 16'd3;
        vecs[0].gap = 8'd0; vecs[0].qos = 2'd2; vecs[0].npkt = 3;
        for (int i = 0; i < 3; i++) begin vecs[0].exp_dst[i] = 8'd1; vecs[0].exp_qos[i] = 2'd2; end
        // SWEEP self 5: 0..4, 6..15
        vecs[1].self_id = 8'd5; vecs[1].mode = 2'd1; vecs[1].count = 16'd15;
        vecs[1].gap = 8'd0; vecs[1].qos = 2'd1; vecs[1].npkt = 15;
        k = 0;
        for (int d = 0; d < 16; d++) if (d != 5) begin
            vecs[1].exp_dst[k] = 8'(d); vecs[1].exp_qos[k] = 2'd1; k++;
        end
        // SWEEP self 0, gap 1: 1..15 then wrap to 1, 2
        vecs[2].self_id = 8'd0; vecs[2].mode = 2'd1; vecs[2].count = 16'd17;
        vecs[2].gap = 8'd1; vecs[2].qos = 2'd3; vecs[2].npkt = 17;
        for (int d = 1; d < 16; d++) vecs[2].exp_dst[d-1] = 8'(d);
        vecs[2].exp_dst[15] = 8'd1; vecs[2].exp_dst[16] = 8'd2;
        for (int i = 0; i < 17; i++) vecs[2].exp_qos[i] = 2'd3;
        // QOS_CYCLE self 3 -> 12, gap 1: LOW NORMAL HIGH URGENT LOW
        vecs[3].self_id = 8'd3; vecs[3].mode = 2'd3; vecs[3].dst = 8'd12; vecs[3].count = 16'd5;
        vecs[3].gap = 8'd1; vecs[3].qos = 2'd3; vecs[3].npkt = 5;
        for (int i = 0; i < 5; i++) begin vecs[3].exp_dst[i] = 8'd12; vecs[3].exp_qos[i] = 2'(i % 4); end
        // RANDOM self 0, seed 0 (becomes 1): lfsr 1,2,4,8,10,20,..,400,801,1002,2005
        vecs[4].self_id = 8'd0; vecs[4].mode = 2'd2; vecs[4].count = 16'd14;
        vecs[4].gap = 8'd0; vecs[4].qos = 2'd0; vecs[4].seed = 16'd0; vecs[4].npkt = 14;
        vecs[4].exp_dst[0] = 8'd1; vecs[4].exp_dst[1] = 8'd2; vecs[4].exp_dst[2] = 8'd4;
        vecs[4].exp_dst[3] = 8'd8;
        for (int i = 4; i < 12; i++) vecs[4].exp_dst[i] = 8'd1;
        vecs[4].exp_dst[12] = 8'd2; vecs[4].exp_dst[13] = 8'd5;
        // SWEEP self 15: 0..14 then wrap to 0
        vecs[5].self_id = 8'd15; vecs[5].mode = 2'd1; vecs[5].count = 16'd16;
        vecs[5].gap = 8'd0; vecs[5].qos = 2'd0; vecs[5].npkt = 16;
        for (int d = 0; d < 15; d++) vecs[5].exp_dst[d] = 8'(d);
        vecs[5].exp_dst[15] = 8'd0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int n, idle, got_done;
        do_reset();
        self_id = v.self_id; cfg_mode = v.mode; cfg_dst = v.dst; cfg_count = v.count;
        cfg_gap = v.gap; cfg_qos = qos_level_t'(v.qos); cfg_seed = v.seed; pe_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check($sformatf("v%0d busy_after_start", idx), 256'(busy), 256'd1);
        n = 0; idle = 0; got_done = 0;
        for (int c = 0; c < 400; c++) begin
            if (done) begin got_done = 1; break; end
            if (pe_write) begin
                if (n < 20) begin
                    check($sformatf("v%0d p%0d addr", idx, n), 256'(pe_addr), exp_addr(int'(v.exp_dst[n])));
                    check($sformatf("v%0d p%0d wdata", idx, n), pe_wdata, exp_wdata(v.self_id, n));
                    check($sformatf("v%0d p%0d qos", idx, n), 256'(pe_qos), 256'(v.exp_qos[n]));
                end
                if (n > 0) check($sformatf("v%0d p%0d gap", idx, n), 256'(idle), 256'(v.gap));
                n++;
                idle = 0;
            end else begin
                idle++;
            end
            tick();
        end
        check($sformatf("v%0d done_seen", idx), 256'(got_done), 256'd1);
        check($sformatf("v%0d packets", idx), 256'(n), 256'(v.npkt));
        check($sformatf("v%0d tx_count", idx), 256'(tx_count), 256'(v.npkt));
        check($sformatf("v%0d busy_in_done", idx), 256'(busy), 256'd1);
        tick();
        check($sformatf("v%0d busy_after_done", idx), 256'(busy), 256'd0);
        check($sformatf("v%0d done_one_cycle", idx), 256'(done), 256'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        self_id = 8'd0; pe_rdata = '0;
        set_cfg(8'd0, 2'd0, 8'd1, 16'd1, 8'd0);
        init_vecs();

        // Reset values
        rst = 1'b1; start = 1'b0; stop = 1'b0; pe_ready = 1'b0; pe_valid = 1'b0;
        tick();
        check("rst pe_write", 256'(pe_write), 256'd0);
        check("rst busy", 256'(busy), 256'd0);
        check("rst done", 256'(done), 256'd0);
        check("rst cfg_err", 256'(cfg_err), 256'd0);
        check("rst pe_read", 256'(pe_read), 256'd0);
        check("rst pe_size", 256'(pe_size), 256'd3);
        check("rst pe_qos", 256'(pe_qos), 256'(QOS_NORMAL));
        check("rst pe_addr", 256'(pe_addr), 256'd0);
        check("rst pe_wdata", pe_wdata, 256'd0);
        check("rst counters", 256'({tx_count, rx_count, stall_cycles}), 256'd0);
        rst = 1'b0;
        tick();

        // Receive counting
        pe_valid = 1'b1;
        repeat (3) tick();
        pe_valid = 1'b0;
        tick();
        check("rx_count", 256'(rx_count), 256'd3);

        // Table-driven whole runs
        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Backpressure: ready low for 7 cycles on the first packet
        do_reset();
        set_cfg(8'd0, 2'd0, 8'd1, 16'd2, 8'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 7; c++) begin
            check($sformatf("bp hold%0d write", c), 256'(pe_write), 256'd1);
            check($sformatf("bp hold%0d wdata", c), pe_wdata, exp_wdata(8'd0, 0));
            check($sformatf("bp hold%0d addr", c), 256'(pe_addr), exp_addr(1));
            tick();
        end
        check("bp stall_cycles", 256'(stall_cycles), 256'd7);
        check("bp tx_before_ready", 256'(tx_count), 256'd0);
        pe_ready = 1'b1;
        tick();
        check("bp tx_after_ready", 256'(tx_count), 256'd1);
        check("bp next_seq", pe_wdata, exp_wdata(8'd0, 1));
        tick();
        check("bp done", 256'(done), 256'd1);
        check("bp tx_final", 256'(tx_count), 256'd2);
        check("bp stall_final", 256'(stall_cycles), 256'd7);

        // Start rejection, and start+stop together
        do_reset();
        set_cfg(8'd2, 2'd0, 8'd2, 16'd3, 8'd0);
        pe_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("rej self cfg_err", 256'(cfg_err), 256'd1);
        check("rej self busy", 256'(busy), 256'd0);
        check("rej self write", 256'(pe_write), 256'd0);
        tick();
        check("rej self cfg_err_pulse", 256'(cfg_err), 256'd0);
        check("rej self still_idle", 256'(busy), 256'd0);
        set_cfg(8'd2, 2'd3, 8'd16, 16'd3, 8'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("rej range cfg_err", 256'(cfg_err), 256'd1);
        check("rej range busy", 256'(busy), 256'd0);
        set_cfg(8'd2, 2'd0, 8'd3, 16'd3, 8'd0);
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        check("startstop busy", 256'(busy), 256'd0);
        check("startstop cfg_err", 256'(cfg_err), 256'd0);
        check("rej tx_count", 256'(tx_count), 256'd0);

        // Stop in IDLE is ignored; then unbounded run stopped with 5th packet in flight
        do_reset();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("idle_stop busy", 256'(busy), 256'd0);
        set_cfg(8'd0, 2'd0, 8'd3, 16'd0, 8'd2);
        pe_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        acc = 0;
        for (int c = 0; c < 100 && acc < 4; c++) begin
            if (pe_write) acc++;
            tick();
        end
        check("stop accepts", 256'(acc), 256'd4);
        // start while busy is ignored, even with a different destination
        cfg_dst = 8'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (pe_write) break;
            tick();
        end
        pe_ready = 1'b0;
        check("stop 5th write", 256'(pe_write), 256'd1);
        check("stop 5th addr", 256'(pe_addr), exp_addr(3));
        check("stop 5th wdata", pe_wdata, exp_wdata(8'd0, 4));
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop inflight write", 256'(pe_write), 256'd1);
        check("stop inflight done", 256'(done), 256'd0);
        pe_ready = 1'b1;
        tick();
        check("stop done", 256'(done), 256'd1);
        check("stop tx_count", 256'(tx_count), 256'd5);
        check("stop write_low", 256'(pe_write), 256'd0);
        tick();
        check("stop idle", 256'(busy), 256'd0);

        // Stop during GAP ends the run on the next cycle
        do_reset();
        set_cfg(8'd0, 2'd0, 8'd1, 16'd0, 8'd3);
        pe_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("gapstop in_gap", 256'({busy, pe_write}), 256'b10);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("gapstop done", 256'(done), 256'd1);
        check("gapstop tx", 256'(tx_count), 256'd1);

        // Reset mid-run, then a fresh start begins at seq 0
        do_reset();
        set_cfg(8'd0, 2'd0, 8'd1, 16'd0, 8'd0);
        pe_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("midrst pre_write", 256'(pe_write), 256'd1);
        check("midrst pre_seq", pe_wdata, exp_wdata(8'd0, 2));
        #2 rst = 1'b1;
        #1;
        check("midrst write_async", 256'(pe_write), 256'd0);
        check("midrst busy_async", 256'(busy), 256'd0);
        check("midrst tx_cleared", 256'(tx_count), 256'd0);
        tick();
        rst = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("midrst restart_write", 256'(pe_write), 256'd1);
        check("midrst restart_seq", pe_wdata, exp_wdata(8'd0, 0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
